// File: rtl/seq_approx_div_pkg.sv
// Shared types and helpers for the sequential approximate restoring divider.
// State encoding, approximate-cell truth tables and the triangle cell-select rule.
package seq_approx_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Approximate subtractor cell outputs, indexed by {x, y, bin}.
    localparam logic [7:0] APX_DIFF_TT = 8'b0010_0111;
    localparam logic [7:0] APX_BOUT_TT = 8'b0100_0110;

    // Cells whose row index plus column index fall inside the triangle are approximate.
    function automatic logic is_approx(input int i, input int j, input int depth);
        return (i + j) < depth;
    endfunction

endpackage

// File: rtl/seq_approx_divider_row.sv
// One combinational restoring-division row: trial subtraction of d from {R, n-bit}
// through a D_W-cell borrow chain mixing exact and approximate cells.
module div_row
    import seq_approx_div_pkg::*;
#(
    parameter int D_W          = 8,
    parameter int APPROX_DEPTH = 4
) (
    input  logic [D_W-1:0] rem_in,
    input  logic           n_bit,
    input  logic [D_W-1:0] d,
    input  int             row_i,
    input  logic           exact,
    output logic           q_bit,
    output logic [D_W-1:0] rem_out
);

    logic [D_W:0]   t;
    logic [D_W-1:0] diff;
    logic [D_W:0]   borrow;

    assign t         = {rem_in, n_bit};
    assign borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < D_W; gi++) begin : g_cell
            logic       x;
            logic       y;
            logic       b;
            logic       approx;
            logic [2:0] idx;

            assign x      = t[gi];
            assign y      = d[gi];
            assign b      = borrow[gi];
            assign idx    = {x, y, b};
            assign approx = !exact && is_approx(row_i, gi, APPROX_DEPTH);

            assign diff[gi]     = approx ? APX_DIFF_TT[idx] : (x ^ y ^ b);
            assign borrow[gi+1] = approx ? APX_BOUT_TT[idx] : ((~x & y) | (~(x ^ y) & b));
        end
    endgenerate

    // A set top bit of T means T already exceeds any D_W-bit divisor.
    assign q_bit   = t[D_W] | ~borrow[D_W];
    assign rem_out = q_bit ? diff : t[D_W-1:0];

endmodule

// File: rtl/seq_approx_divider.sv
// Iterative restoring divider with a triangular approximate low-significance region,
// STEPS quotient bits per cycle, valid/ready on both sides. Optional: ADIV_EXACT_MODE_EN.
module seq_approx_divider
    import seq_approx_div_pkg::*;
#(
    parameter int N_W          = 16,
    parameter int D_W          = 8,
    parameter int STEPS        = 1,
    parameter int APPROX_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_W-1:0]     n,
    input  logic [D_W-1:0]     d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_W-D_W-1:0] q,
    output logic [D_W-1:0]     r,
    output logic               dbz,
    output logic               ovf
`ifdef ADIV_EXACT_MODE_EN
    ,
    input  logic               exact_mode
`endif
);

    localparam int Q_W = N_W - D_W;
    localparam int KW  = $clog2(Q_W + 1);

    state_t state_reg, state_next;

    logic [Q_W-1:0] nlo_reg;
    logic [D_W-1:0] d_reg;
    logic [D_W-1:0] rem_reg;
    logic [Q_W-1:0] q_reg;
    logic [Q_W-1:0] q_next;
    logic [KW-1:0]  k_reg;
    logic           dbz_reg;
    logic           ovf_reg;
    logic           exact_ovr;
    logic           last_cycle;

    logic [D_W-1:0] rem_chain [STEPS+1];
    logic [STEPS-1:0] q_bits;

`ifdef ADIV_EXACT_MODE_EN
    logic exact_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact_reg <= 1'b0;
        end else if (state_reg == IDLE && in_valid) begin
            exact_reg <= exact_mode;
        end
    end

    assign exact_ovr = exact_reg;
`else
    assign exact_ovr = 1'b0;
`endif

    assign last_cycle = (k_reg == KW'(Q_W - STEPS));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = (d == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_cycle) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Row chain: step gi resolves quotient bit Q_W-1-k-gi this cycle.
    assign rem_chain[0] = rem_reg;

    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_row
            int row_idx;

            assign row_idx = Q_W - 1 - gi - int'(k_reg);

            div_row #(
                .D_W          (D_W),
                .APPROX_DEPTH (APPROX_DEPTH)
            ) u_row (
                .rem_in  (rem_chain[gi]),
                .n_bit   (nlo_reg[Q_W-1-gi]),
                .d       (d_reg),
                .row_i   (row_idx),
                .exact   (exact_ovr),
                .q_bit   (q_bits[gi]),
                .rem_out (rem_chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        q_next = q_reg << STEPS;
        for (int s = 0; s < STEPS; s++) begin
            q_next[STEPS-1-s] = q_bits[s];
        end
    end

    // Datapath: operands are latched on acceptance, low dividend bits shift out MSB-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nlo_reg <= '0;
            d_reg   <= '0;
            rem_reg <= '0;
            q_reg   <= '0;
            k_reg   <= '0;
            dbz_reg <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        nlo_reg <= n[Q_W-1:0];
                        d_reg   <= d;
                        k_reg   <= '0;
                        if (d == '0) begin
                            q_reg   <= '1;
                            rem_reg <= n[D_W-1:0];
                            dbz_reg <= 1'b1;
                            ovf_reg <= 1'b0;
                        end else begin
                            q_reg   <= '0;
                            rem_reg <= n[N_W-1:Q_W];
                            dbz_reg <= 1'b0;
                            ovf_reg <= (n[N_W-1:Q_W] >= d);
                        end
                    end
                end
                CALC: begin
                    rem_reg <= rem_chain[STEPS];
                    q_reg   <= q_next;
                    nlo_reg <= nlo_reg << STEPS;
                    k_reg   <= k_reg + KW'(STEPS);
                end
                default: ;
            endcase
        end
    end

    assign q   = q_reg;
    assign r   = rem_reg;
    assign dbz = dbz_reg;
    assign ovf = ovf_reg;

endmodule

// File: tb/tb_seq_approx_divider.sv
// Self-checking bench: four divider configurations driven in lockstep, checked against
// an arithmetic/cell-level reference model, a vector table and handshake/reset sequences.
module tb_seq_approx_divider;

    localparam int NDUT = 4;
    localparam int CFG_DEPTH [NDUT] = '{0, 4, 4, 4};
    localparam int CFG_STEPS [NDUT] = '{1, 1, 2, 4};

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] n_in;
    logic [7:0]  d_in;
`ifdef ADIV_EXACT_MODE_EN
    logic        exact_mode;
`endif

    logic       in_ready_o  [NDUT];
    logic       out_valid_o [NDUT];
    logic [7:0] q_o         [NDUT];
    logic [7:0] r_o         [NDUT];
    logic       dbz_o       [NDUT];
    logic       ovf_o       [NDUT];

    int pass_cnt;
    int total_cnt;

    int res_q   [NDUT];
    int res_r   [NDUT];
    int res_dbz [NDUT];
    int res_ovf [NDUT];
    int res_lat [NDUT];

    int apx_d [8] = '{1, 1, 1, 0, 0, 1, 0, 0};
    int apx_b [8] = '{0, 1, 1, 0, 0, 0, 1, 0};

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            seq_approx_divider #(
                .N_W          (16),
                .D_W          (8),
                .STEPS        (CFG_STEPS[gi]),
                .APPROX_DEPTH (CFG_DEPTH[gi])
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .in_valid   (in_valid),
                .in_ready   (in_ready_o[gi]),
                .n          (n_in),
                .d          (d_in),
                .out_valid  (out_valid_o[gi]),
                .out_ready  (out_ready),
                .q          (q_o[gi]),
                .r          (r_o[gi]),
                .dbz        (dbz_o[gi]),
                .ovf        (ovf_o[gi])
`ifdef ADIV_EXACT_MODE_EN
                ,
                .exact_mode (exact_mode)
`endif
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference: row-by-row long division on integers; cells evaluated from the truth
    // table (approximate) or from signed bit subtraction (exact).
    function automatic void model(input int nv, input int dv, input int depth, input bit ex,
                                  output int qo, output int ro, output int ovo);
        int rem, t, brw, diff, qb, x, y, s, idx;
        qo  = 0;
        ovo = 0;
        if (dv == 0) begin
            qo = 255;
            ro = nv & 255;
            return;
        end
        rem = nv >> 8;
        ovo = (rem >= dv) ? 1 : 0;
        for (int i = 7; i >= 0; i--) begin
            t    = (rem << 1) | ((nv >> i) & 1);
            brw  = 0;
            diff = 0;
            for (int j = 0; j < 8; j++) begin
                x = (t >> j) & 1;
                y = (dv >> j) & 1;
                if (!ex && (i + j) < depth) begin
                    idx  = x * 4 + y * 2 + brw;
                    diff = diff | (apx_d[idx] << j);
                    brw  = apx_b[idx];
                end else begin
                    s    = x - y - brw;
                    diff = diff | ((s & 1) << j);
                    brw  = (s < 0) ? 1 : 0;
                end
            end
            qb  = (((t >> 8) & 1) == 1 || brw == 0) ? 1 : 0;
            qo  = qo | (qb << i);
            rem = (qb == 1) ? diff : (t & 255);
        end
        ro = rem;
    endfunction

    // One transaction on all DUTs in lockstep, then checks every DUT against the model.
    task automatic run_op(input int nv, input int dv, input bit em);
        bit all_done;
        int mq, mr, mo, exp_lat;
        n_in     = nv[15:0];
        d_in     = dv[7:0];
`ifdef ADIV_EXACT_MODE_EN
        exact_mode = em;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            res_lat[i] = -1;
            res_q[i]   = 0;
            res_r[i]   = 0;
            res_dbz[i] = 0;
            res_ovf[i] = 0;
        end
        for (int c = 0; c <= 40; c++) begin
            all_done = 1'b1;
            for (int i = 0; i < NDUT; i++) begin
                if (res_lat[i] < 0 && out_valid_o[i]) begin
                    res_lat[i] = c;
                    res_q[i]   = int'(q_o[i]);
                    res_r[i]   = int'(r_o[i]);
                    res_dbz[i] = int'(dbz_o[i]);
                    res_ovf[i] = int'(ovf_o[i]);
                end
                if (res_lat[i] < 0) all_done = 1'b0;
            end
            if (all_done) break;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            model(nv, dv, CFG_DEPTH[i], em, mq, mr, mo);
            exp_lat = (dv == 0) ? 0 : 8 / CFG_STEPS[i];
            chk($sformatf("q[cfg%0d]", i), res_q[i], mq);
            chk($sformatf("r[cfg%0d]", i), res_r[i], mr);
            chk($sformatf("dbz[cfg%0d]", i), res_dbz[i], (dv == 0) ? 1 : 0);
            chk($sformatf("ovf[cfg%0d]", i), res_ovf[i], mo);
            chk($sformatf("latency[cfg%0d]", i), res_lat[i], exp_lat);
        end
        $display("op n=%04h d=%02h em=%0d q=%02h/%02h/%02h/%02h r=%02h/%02h/%02h/%02h",
                 nv, dv, em, res_q[0], res_q[1], res_q[2], res_q[3],
                 res_r[0], res_r[1], res_r[2], res_r[3]);
    endtask

    initial begin
        int nv, dv, hold_q, hold_r, wait_cnt;
        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0] = '{16'd1000,  8'd7,    8'd142,  8'd6,    1'b0, 1'b0};
        vecs[1] = '{16'h1234,  8'd0,    8'hFF,   8'h34,   1'b1, 1'b0};
        vecs[2] = '{16'h0900,  8'd8,    8'hFF,   8'h08,   1'b0, 1'b1};
        vecs[3] = '{16'd255,   8'd1,    8'd255,  8'd0,    1'b0, 1'b0};
        vecs[4] = '{16'd0,     8'd5,    8'd0,    8'd0,    1'b0, 1'b0};
        vecs[5] = '{16'h7FFF,  8'h80,   8'd255,  8'd127,  1'b0, 1'b0};
        vecs[6] = '{16'd12345, 8'd100,  8'd123,  8'd45,   1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_in      = '0;
        d_in      = '0;
`ifdef ADIV_EXACT_MODE_EN
        exact_mode = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("reset_in_ready[cfg%0d]", i), int'(in_ready_o[i]), 1);
            chk($sformatf("reset_out_valid[cfg%0d]", i), int'(out_valid_o[i]), 0);
            chk($sformatf("reset_q[cfg%0d]", i), int'(q_o[i]), 0);
            chk($sformatf("reset_r[cfg%0d]", i), int'(r_o[i]), 0);
            chk($sformatf("reset_flags[cfg%0d]", i), int'({dbz_o[i], ovf_o[i]}), 0);
        end

        // Vector table against the exact configuration
        for (int v = 0; v < 7; v++) begin
            run_op(int'(vecs[v].n), int'(vecs[v].d), 1'b0);
            chk($sformatf("vec%0d_q", v), res_q[0], int'(vecs[v].q));
            chk($sformatf("vec%0d_r", v), res_r[0], int'(vecs[v].r));
            chk($sformatf("vec%0d_dbz", v), res_dbz[0], int'(vecs[v].dbz));
            chk($sformatf("vec%0d_ovf", v), res_ovf[0], int'(vecs[v].ovf));
        end

        // Hold in DONE with out_ready low; an in_valid pulse must be ignored
        n_in     = 16'd1000;
        d_in     = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!(out_valid_o[0] && out_valid_o[1] && out_valid_o[2] && out_valid_o[3])
               && wait_cnt < 40) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        chk("hold_reach_done", int'(out_valid_o[0]), 1);
        hold_q = int'(q_o[0]);
        hold_r = int'(r_o[0]);
        chk("hold_q_start", hold_q, 142);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                n_in     = 16'd5;
                d_in     = 8'd3;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_q", c), int'(q_o[0]), hold_q);
            chk($sformatf("hold%0d_r", c), int'(r_o[0]), hold_r);
            chk($sformatf("hold%0d_in_ready", c), int'(in_ready_o[0]), 0);
            chk($sformatf("hold%0d_out_valid", c), int'(out_valid_o[3]), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_out_valid", int'(out_valid_o[0]), 0);
        chk("release_in_ready", int'(in_ready_o[0]), 1);
        run_op(12345, 100, 1'b0);
        chk("after_hold_q", res_q[0], 123);

        // Asynchronous reset in the third CALC cycle
        n_in     = 16'd40000;
        d_in     = 8'd200;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid_o[0]), 0);
        chk("abort_in_ready", int'(in_ready_o[0]), 1);
        chk("abort_in_ready_s4", int'(in_ready_o[3]), 1);
        chk("abort_q", int'(q_o[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(1000, 7, 1'b0);
        chk("post_abort_q", res_q[0], 142);
        chk("post_abort_r", res_r[0], 6);

`ifdef ADIV_EXACT_MODE_EN
        run_op(1000, 7, 1'b1);
        chk("exact_mode_q", res_q[1], 142);
        chk("exact_mode_r", res_r[1], 6);
`endif

        // Random operands, mostly in the representable range
        for (int t = 0; t < 1000; t++) begin
            if (t % 10 == 9) begin
                nv = int'($urandom_range(0, 65535));
                dv = int'($urandom_range(0, 255));
            end else begin
                dv = int'($urandom_range(1, 255));
                nv = (int'($urandom_range(0, dv - 1)) << 8) | int'($urandom_range(0, 255));
            end
            run_op(nv, dv, 1'b0);
            if (dv != 0 && (nv >> 8) < dv) begin
                chk("rand_exact_div_q", res_q[0], nv / dv);
                chk("rand_exact_div_r", res_r[0], nv % dv);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
